namuru_timebase_ctrl: RTL and testbench
=======================================

// Module: namuru_timebase_ctrl
// PURPOSE
//  Configures and supervises time_base: holds host-written TIC/ACCUM divide values in shadow
//  registers and commits them only on period boundaries, so the down-counters never see a mid-period change.
//  Turns accum_enable pulses into a sticky accumulation-interrupt flag, with a saturating overrun count.
//  Sits between the host register bus and time_base; its divide outputs drive time_base directly.
// PARAMETERS
//  DW          24        divide/counter width (matches time_base)
//  OVR_W       8         overrun counter width
//  MIN_DIVIDE  24'h00000F  writes below this are clamped up to it (a divide of 0 would stall time_base)
// PORTS
//  clk             in   1   system clock (sample clock domain)
//  rstn            in   1   reset: synchronous, ACTIVE-HIGH despite the name
//  wr_en           in   1   host write strobe, one cycle per write
//  wr_addr         in   2   0 = tic shadow, 1 = accum shadow, 2 = control, 3 = reserved (ignored)
//  wr_data         in   DW  write data; control uses bit0 = clear accum_int, bit1 = clear overrun count
//  rd_addr         in   2   0 = tic active, 1 = accum active, 2 = status, 3 = epoch (see CONFIGURATION)
//  rd_data         out  32  registered read data, 1-cycle latency
//  pre_tic_enable  in   1   from time_base
//  tic_enable      in   1   from time_base (pre_tic_enable delayed by 1 clk)
//  accum_enable    in   1   from time_base
//  tic_divide      out  DW  active TIC divide to time_base
//  accum_divide    out  DW  active ACCUM divide to time_base
//  accum_int       out  1   sticky accumulation interrupt
// BEHAVIOUR
//  Reset values:
//   - tic_divide = 24'h18FFFF (0.1 s at 16.384 MHz); accum_divide = 24'h1FFF (0.5 ms).
//   - Shadows equal the active values. tic_pend = accum_pend = 0. accum_int = 0, ovr_cnt = 0, rd_data = 0.
//  Shadow write: wr_addr 0/1 loads the shadow with max(wr_data, MIN_DIVIDE) and sets its pend bit.
//  Commit FSM (one per divide, states IDLE -> PEND -> IDLE):
//   - TIC: PEND leaves on the first clk edge where tic_enable = 1. The active value updates on that edge.
//     time_base reloaded the old value one cycle earlier (on pre_tic_enable), so the new value takes
//     effect from the following reload. Latency is one full TIC period plus 1 clk.
//   - ACCUM: PEND leaves on the first clk edge after the edge where accum_enable = 1. The same rule
//     applies: the value is never changed on the reload cycle.
//  Simultaneous write and commit: the commit takes the OLD shadow. The new write lands in the shadow
//   and pend stays 1, so it is committed at the next boundary.
//  accum_int: set on the edge where accum_enable = 1; cleared by a control write with bit0 = 1.
//   - accum_enable with accum_int already 1: ovr_cnt += 1, saturating at 2^OVR_W-1.
//   - clear and accum_enable on the same edge: accum_int = 1 and ovr_cnt is unchanged.
//   - control bit1 clears ovr_cnt. If an overrun occurs on the same edge, ovr_cnt = 1.
//  Status word: {.., ovr_cnt[OVR_W-1:0] at [15:8], accum_pend [2], tic_pend [1], accum_int [0]}.
//  rstn mid-operation: pending writes are discarded and all state returns to reset values on the next edge.
// CONFIGURATION
//  TB_EPOCH_EN defined:
//   - 32-bit epoch counter, reset to 0, increments on each tic_enable and wraps 0xFFFFFFFF -> 0.
//   - Readable at rd_addr 3.
//  TB_EPOCH_EN undefined: no counter; rd_addr 3 returns 0.
// STRUCTURE
//  Shared package/include namuru_tb_pkg:
//   - DW, TB_TIC_DEFAULT = 24'h18FFFF, TB_ACCUM_DEFAULT = 24'h1FFF
//   - address constants TB_A_TIC / TB_A_ACC / TB_A_CTRL / TB_A_EPOCH
//   - status bit indices
//  Sub-module: namuru_shadow_reg (shadow + pend + commit FSM), instantiated twice with a commit-strobe input.
// TESTING
//  1. Release reset -> tic_divide = 24'h18FFFF, accum_divide = 24'h1FFF, accum_int = 0, status = 0.
//  2. Write tic 24'h0003FF mid-period -> tic_pend = 1. tic_divide is unchanged until the tic_enable edge,
//     then reads 24'h0003FF; next time_base period = 1024 clk.
//  3. Write accum 24'h000005 -> clamped to 24'h00000F. Committed 1 clk after accum_enable. The following
//     ACCUM period is 16 clk.
//  4. Three accum_enable pulses with no clear -> accum_int = 1, ovr_cnt = 2. Clear (ctrl = 3) -> both 0.
//  5. Same-cycle cases:
//     - control clear with accum_enable -> accum_int stays 1, ovr_cnt unchanged.
//     - tic write on the commit edge -> old value committed, tic_pend = 1.
//  6. Assert rstn while both pend bits are set -> pend bits drop and divides return to defaults.
//     With TB_EPOCH_EN, epoch reads 0, then 5 after 5 tic_enable pulses.

Source files
------------

// File: rtl/namuru_tb_pkg.sv
// Shared constants for the time_base controller: widths, reset divides,
// register addresses and status/control bit positions.
package namuru_tb_pkg;
    localparam int DW    = 24;
    localparam int OVR_W = 8;

    localparam logic [23:0] TB_TIC_DEFAULT   = 24'h18FFFF;  // 0.1 s at 16.384 MHz
    localparam logic [23:0] TB_ACCUM_DEFAULT = 24'h001FFF;  // 0.5 ms
    localparam logic [23:0] TB_MIN_DIVIDE    = 24'h00000F;

    localparam logic [1:0] TB_A_TIC    = 2'd0;
    localparam logic [1:0] TB_A_ACC    = 2'd1;
    localparam logic [1:0] TB_A_CTRL   = 2'd2;
    localparam logic [1:0] TB_A_STATUS = 2'd2;
    localparam logic [1:0] TB_A_EPOCH  = 2'd3;

    localparam int TB_S_INT      = 0;
    localparam int TB_S_TIC_PEND = 1;
    localparam int TB_S_ACC_PEND = 2;
    localparam int TB_S_OVR_LSB  = 8;

    localparam int TB_C_CLR_INT = 0;
    localparam int TB_C_CLR_OVR = 1;

    typedef enum logic {SH_IDLE, SH_PEND} sh_state_e;
endpackage

// File: rtl/namuru_timebase_ctrl_if.sv
// Host register bus for the time_base controller.
interface namuru_timebase_ctrl_if #(parameter int DW = 24);
    logic          wr_en;
    logic [1:0]    wr_addr;
    logic [DW-1:0] wr_data;
    logic [1:0]    rd_addr;
    logic [31:0]   rd_data;

    modport master (output wr_en, wr_addr, wr_data, rd_addr, input rd_data);
    modport slave  (input wr_en, wr_addr, wr_data, rd_addr, output rd_data);
endinterface

// File: rtl/namuru_shadow_reg.sv
// Shadowed divide register: host writes land in the shadow, and the active
// value only follows on a commit strobe while a write is pending.
module namuru_shadow_reg
    import namuru_tb_pkg::*;
#(
    parameter int           W       = 24,
    parameter logic [W-1:0] RST_VAL = '0,
    parameter logic [W-1:0] MIN_VAL = '0
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         wr,
    input  logic [W-1:0] wr_data,
    input  logic         commit,
    output logic [W-1:0] active,
    output logic         pend
);
    sh_state_e    state_q;
    logic [W-1:0] shadow_q;
    logic [W-1:0] active_q;

    always_ff @(posedge clk) begin
        if (rstn) begin
            state_q  <= SH_IDLE;
            shadow_q <= RST_VAL;
            active_q <= RST_VAL;
        end else begin
            case (state_q)
                SH_IDLE: if (wr) state_q <= SH_PEND;
                SH_PEND: if (commit) begin
                    // commit uses the pre-edge shadow; a same-edge write stays pending
                    active_q <= shadow_q;
                    state_q  <= wr ? SH_PEND : SH_IDLE;
                end
            endcase
            if (wr) shadow_q <= (wr_data < MIN_VAL) ? MIN_VAL : wr_data;
        end
    end

    assign active = active_q;
    assign pend   = (state_q == SH_PEND);
endmodule

// File: rtl/namuru_timebase_ctrl.sv
// time_base supervisor: period-aligned divide commits, sticky accum interrupt
// with saturating overrun count. Define TB_EPOCH_EN to add the tic epoch counter.
module namuru_timebase_ctrl
    import namuru_tb_pkg::*;
#(
    parameter int           DW         = 24,
    parameter int           OVR_W      = 8,
    parameter logic [DW-1:0] MIN_DIVIDE = 24'h00000F
) (
    input  logic                  clk,
    input  logic                  rstn,
    namuru_timebase_ctrl_if.slave bus,
    input  logic                  pre_tic_enable,
    input  logic                  tic_enable,
    input  logic                  accum_enable,
    output logic [DW-1:0]         tic_divide,
    output logic [DW-1:0]         accum_divide,
    output logic                  accum_int
);
    logic             tic_wr, acc_wr, ctrl_wr, clr_int, clr_ovr, overrun;
    logic             tic_pend, acc_pend;
    logic             accum_en_q;
    logic             accum_int_q, accum_int_d;
    logic [OVR_W-1:0] ovr_cnt_q, ovr_cnt_d;
    logic [31:0]      rd_data_q, rd_data_d, status;
    logic [31:0]      epoch_q, epoch_d;

    assign tic_wr  = bus.wr_en && (bus.wr_addr == TB_A_TIC);
    assign acc_wr  = bus.wr_en && (bus.wr_addr == TB_A_ACC);
    assign ctrl_wr = bus.wr_en && (bus.wr_addr == TB_A_CTRL);

    // never commit on a reload cycle, even if the enables were ever to coincide
    namuru_shadow_reg #(.W(DW), .RST_VAL(TB_TIC_DEFAULT), .MIN_VAL(MIN_DIVIDE)) u_tic (
        .clk(clk), .rstn(rstn), .wr(tic_wr), .wr_data(bus.wr_data),
        .commit(tic_enable && !pre_tic_enable), .active(tic_divide), .pend(tic_pend)
    );

    // accum reloads on accum_enable itself, so commit one cycle later
    namuru_shadow_reg #(.W(DW), .RST_VAL(TB_ACCUM_DEFAULT), .MIN_VAL(MIN_DIVIDE)) u_acc (
        .clk(clk), .rstn(rstn), .wr(acc_wr), .wr_data(bus.wr_data),
        .commit(accum_en_q), .active(accum_divide), .pend(acc_pend)
    );

    always_comb begin
        clr_int = ctrl_wr && bus.wr_data[TB_C_CLR_INT];
        clr_ovr = ctrl_wr && bus.wr_data[TB_C_CLR_OVR];
        // a clear racing a new event is treated as acknowledging the old one
        overrun = accum_enable && accum_int_q && !clr_int;

        accum_int_d = accum_int_q;
        if (clr_int)      accum_int_d = 1'b0;
        if (accum_enable) accum_int_d = 1'b1;

        ovr_cnt_d = ovr_cnt_q;
        if (clr_ovr)
            ovr_cnt_d = overrun ? OVR_W'(1) : '0;
        else if (overrun && (ovr_cnt_q != '1))
            ovr_cnt_d = ovr_cnt_q + OVR_W'(1);

        status                              = '0;
        status[TB_S_INT]                    = accum_int_q;
        status[TB_S_TIC_PEND]               = tic_pend;
        status[TB_S_ACC_PEND]               = acc_pend;
        status[TB_S_OVR_LSB +: OVR_W]       = ovr_cnt_q;

`ifdef TB_EPOCH_EN
        epoch_d = epoch_q + 32'(tic_enable);
`else
        epoch_d = '0;
`endif

        case (bus.rd_addr)
            TB_A_TIC:    rd_data_d = 32'(tic_divide);
            TB_A_ACC:    rd_data_d = 32'(accum_divide);
            TB_A_STATUS: rd_data_d = status;
            TB_A_EPOCH:  rd_data_d = epoch_q;
            default:     rd_data_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rstn) begin
            accum_en_q  <= 1'b0;
            accum_int_q <= 1'b0;
            ovr_cnt_q   <= '0;
            rd_data_q   <= '0;
            epoch_q     <= '0;
        end else begin
            accum_en_q  <= accum_enable;
            accum_int_q <= accum_int_d;
            ovr_cnt_q   <= ovr_cnt_d;
            rd_data_q   <= rd_data_d;
            epoch_q     <= epoch_d;
        end
    end

    assign accum_int   = accum_int_q;
    assign bus.rd_data = rd_data_q;
endmodule

// File: tb/tb_namuru_timebase_ctrl.sv
// Self-checking bench for namuru_timebase_ctrl: directed scenarios plus a
// random phase, all checked every cycle against a behavioural model.
module tb_namuru_timebase_ctrl;
    import namuru_tb_pkg::*;

    logic        clk = 1'b0;
    logic        rstn = 1'b1;
    logic        pte = 1'b0, te = 1'b0, ae = 1'b0;
    logic [23:0] tic_div, acc_div;
    logic        aint;
    int          tests = 0, fails = 0;

    namuru_timebase_ctrl_if #(.DW(24)) bus();

    namuru_timebase_ctrl dut (
        .clk(clk), .rstn(rstn), .bus(bus.slave),
        .pre_tic_enable(pte), .tic_enable(te), .accum_enable(ae),
        .tic_divide(tic_div), .accum_divide(acc_div), .accum_int(aint)
    );

    always #5 clk = ~clk;

    // reference model state
    logic [23:0] m_tic, m_tic_sh, m_acc, m_acc_sh;
    bit          m_tic_p, m_acc_p, m_ae_prev, m_int;
    int          m_ovr;
    logic [31:0] m_epoch, m_rd;

    function automatic logic [23:0] clampf(input logic [23:0] v);
        return (v < 24'h00000F) ? 24'h00000F : v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_update();
        logic [31:0] stat;
        bit ci, co, ovf;
        if (rstn) begin
            m_tic = 24'h18FFFF; m_tic_sh = 24'h18FFFF; m_tic_p = 0;
            m_acc = 24'h001FFF; m_acc_sh = 24'h001FFF; m_acc_p = 0;
            m_ae_prev = 0; m_int = 0; m_ovr = 0; m_epoch = 0; m_rd = 0;
        end else begin
            stat = {16'h0, 8'(m_ovr), 5'h0, m_acc_p, m_tic_p, m_int};
            case (bus.rd_addr)
                2'd0: m_rd = {8'h0, m_tic};
                2'd1: m_rd = {8'h0, m_acc};
                2'd2: m_rd = stat;
`ifdef TB_EPOCH_EN
                default: m_rd = m_epoch;
`else
                default: m_rd = 0;
`endif
            endcase
            if (te && m_tic_p)        begin m_tic = m_tic_sh; m_tic_p = 0; end
            if (m_ae_prev && m_acc_p) begin m_acc = m_acc_sh; m_acc_p = 0; end
            if (bus.wr_en && bus.wr_addr == 2'd0) begin m_tic_sh = clampf(bus.wr_data); m_tic_p = 1; end
            if (bus.wr_en && bus.wr_addr == 2'd1) begin m_acc_sh = clampf(bus.wr_data); m_acc_p = 1; end
            ci  = bus.wr_en && bus.wr_addr == 2'd2 && bus.wr_data[0];
            co  = bus.wr_en && bus.wr_addr == 2'd2 && bus.wr_data[1];
            ovf = ae && m_int && !ci;
            if (co) m_ovr = ovf ? 1 : 0;
            else if (ovf && m_ovr < 255) m_ovr = m_ovr + 1;
            if (ae) m_int = 1; else if (ci) m_int = 0;
            m_ae_prev = ae;
`ifdef TB_EPOCH_EN
            if (te) m_epoch = m_epoch + 1;
`endif
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        @(negedge clk);
        chk("tic_divide", 32'(tic_div), 32'(m_tic));
        chk("accum_divide", 32'(acc_div), 32'(m_acc));
        chk("accum_int", 32'(aint), 32'(m_int));
        chk("rd_data", bus.rd_data, m_rd);
    endtask

    task automatic wr(input logic [1:0] a, input logic [23:0] d);
        bus.wr_en = 1'b1; bus.wr_addr = a; bus.wr_data = d;
        tick();
        bus.wr_en = 1'b0;
    endtask

    task automatic tic_pulse();
        pte = 1'b1; tick(); pte = 1'b0;
        te = 1'b1;  tick(); te = 1'b0;
    endtask

    initial begin
        bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0; bus.rd_addr = 2'd2;

        // reset state
        rstn = 1'b1; tick(); tick(); rstn = 1'b0;
        tick();
        chk("rst_tic", 32'(tic_div), 32'h0018FFFF);
        chk("rst_acc", 32'(acc_div), 32'h00001FFF);
        chk("rst_int", 32'(aint), 32'h0);
        chk("rst_status", bus.rd_data, 32'h0);

        // tic shadow write, held until the tic_enable edge
        wr(TB_A_TIC, 24'h0003FF);
        tick();
        chk("tic_pend", bus.rd_data, 32'h2);
        repeat (3) tick();
        chk("tic_hold", 32'(tic_div), 32'h0018FFFF);
        pte = 1'b1; tick(); pte = 1'b0;
        chk("tic_hold_reload", 32'(tic_div), 32'h0018FFFF);
        te = 1'b1; tick(); te = 1'b0;
        chk("tic_commit", 32'(tic_div), 32'h000003FF);
        tick();
        chk("tic_pend_clr", bus.rd_data, 32'h0);

        // accum write is clamped and commits one cycle after accum_enable
        wr(TB_A_ACC, 24'h000005);
        tick();
        ae = 1'b1; tick(); ae = 1'b0;
        chk("acc_hold", 32'(acc_div), 32'h00001FFF);
        chk("int_set", 32'(aint), 32'h1);
        tick();
        chk("acc_clamp", 32'(acc_div), 32'h0000000F);
        wr(TB_A_CTRL, 24'h3);

        // three events without clear -> two overruns
        repeat (3) begin ae = 1'b1; tick(); ae = 1'b0; repeat (2) tick(); end
        chk("ovr_two", bus.rd_data, 32'h201);
        wr(TB_A_CTRL, 24'h3);
        tick();
        chk("clr_both", bus.rd_data, 32'h0);

        // overrun saturation, then clear racing an overrun
        ae = 1'b1; repeat (260) tick(); ae = 1'b0;
        tick();
        chk("ovr_sat", 32'(bus.rd_data[15:8]), 32'hFF);
        bus.wr_en = 1'b1; bus.wr_addr = TB_A_CTRL; bus.wr_data = 24'h2; ae = 1'b1;
        tick();
        bus.wr_en = 1'b0; ae = 1'b0;
        tick();
        chk("clr_ovr_race", 32'(bus.rd_data[15:8]), 32'h1);
        wr(TB_A_CTRL, 24'h3);

        // clear on the same edge as accum_enable
        ae = 1'b1; tick(); ae = 1'b0;
        ae = 1'b1; tick(); ae = 1'b0;
        bus.wr_en = 1'b1; bus.wr_addr = TB_A_CTRL; bus.wr_data = 24'h1; ae = 1'b1;
        tick();
        bus.wr_en = 1'b0; ae = 1'b0;
        chk("clr_race_int", 32'(aint), 32'h1);
        tick();
        chk("clr_race_status", bus.rd_data, 32'h101);
        wr(TB_A_CTRL, 24'h3);

        // tic write on the commit edge: old shadow commits, new one stays pending
        wr(TB_A_TIC, 24'h000500);
        pte = 1'b1; tick(); pte = 1'b0;
        te = 1'b1; bus.wr_en = 1'b1; bus.wr_addr = TB_A_TIC; bus.wr_data = 24'h000777;
        tick();
        te = 1'b0; bus.wr_en = 1'b0;
        chk("wc_old", 32'(tic_div), 32'h00000500);
        tick();
        chk("wc_pend", 32'(bus.rd_data[1]), 32'h1);
        tic_pulse();
        chk("wc_next", 32'(tic_div), 32'h00000777);

        // random phase against the model
        for (int i = 0; i < 600; i++) begin
            te = pte;
            pte = !pte && ($urandom_range(0, 15) == 0);
            ae = ($urandom_range(0, 11) == 0);
            bus.wr_en   = ($urandom_range(0, 3) == 0);
            bus.wr_addr = 2'($urandom_range(0, 3));
            bus.wr_data = ($urandom_range(0, 1) == 0) ? 24'($urandom_range(0, 31)) : 24'($urandom);
            bus.rd_addr = 2'($urandom_range(0, 3));
            rstn = ($urandom_range(0, 299) == 0);
            tick();
        end
        te = 1'b0; pte = 1'b0; ae = 1'b0; bus.wr_en = 1'b0; rstn = 1'b0;
        tick();

        // reset while both writes are pending
        bus.rd_addr = 2'd2;
        wr(TB_A_CTRL, 24'h3);
        wr(TB_A_TIC, 24'h001234);
        wr(TB_A_ACC, 24'h000040);
        tick();
        chk("both_pend", 32'(bus.rd_data[2:1]), 32'h3);
        rstn = 1'b1; tick(); rstn = 1'b0;
        chk("rst2_tic", 32'(tic_div), 32'h0018FFFF);
        chk("rst2_acc", 32'(acc_div), 32'h00001FFF);
        tick();
        chk("rst2_status", bus.rd_data, 32'h0);

        // epoch readback
        bus.rd_addr = TB_A_EPOCH;
        tick();
        chk("epoch0", bus.rd_data, 32'h0);
        repeat (5) begin tic_pulse(); tick(); end
        tick();
`ifdef TB_EPOCH_EN
        chk("epoch5", bus.rd_data, 32'd5);
`else
        chk("epoch_off", bus.rd_data, 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
